anffl_tex_block_fetch: RTL and testbench

ANFFL_TEX_BLOCK_FETCH -- requirements
Module: anffl_tex_block_fetch

---
 rtl/anffl_tex_block_fetch.sv | 164 ++++++++++++++++
 tb/tb_anffl_tex_block_fetch.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anffl_tex_block_fetch.sv
// Texture block fetcher: maps a texel (u,v) to its 4x4 compressed block,
// reads the block as four 32-bit words and hands it to the decoder.
// Optional one-entry block cache: define ANFFL_TEX_FETCH_CACHE_EN.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   req_*                  texel request (valid/ready)
//   inv                    cache invalidate pulse
//   mem_req_*, mem_addr    word read request (valid/ready)
//   mem_rdata_valid/rdata  read data return
//   out_*                  block + texel offset to decoder (valid/ready)
module anffl_tex_block_fetch #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [11:0]   req_u,
    input  logic [11:0]   req_v,
    input  logic [AW-1:0] req_base,
    input  logic [3:0]    req_pitch_log2,
    input  logic [4:0]    req_format,
    input  logic          inv,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_rdata_valid,
    input  logic [31:0]   mem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data,
    output logic [4:0]    out_format,
    output logic [1:0]    out_x,
    output logic [1:0]    out_y
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t        state;
    state_t        nextState;
    logic [1:0]    beat;
    logic [AW-1:0] blkAddr;
    logic [AW-1:0] reqAddr;
    logic [AW-1:0] blkOff;
    logic          hit;
    logic          accept;
    logic          fetchDone;

    // Block index = row * blocksPerRow + col; 16 bytes per block.
    assign blkOff  = ((AW'(req_v[11:2]) << req_pitch_log2)
                     + AW'(req_u[11:2])) << 4;
    assign reqAddr = req_base + blkOff;

    assign accept    = (state == IDLE) && req_valid;
    assign fetchDone = (state == WAIT) && mem_rdata_valid
                       && (beat == 2'd3);

`ifdef ANFFL_TEX_FETCH_CACHE_EN
    logic          tagValid;
    logic          invSeen;
    logic [AW-1:0] tag;

    // An invalidate coincident with the lookup must not hit stale data.
    assign hit = tagValid && (tag == reqAddr) && !inv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tagValid <= 1'b0;
            invSeen  <= 1'b0;
            tag      <= '0;
        end else begin
            // invSeen remembers an invalidate that arrived mid-fetch so
            // the block still gets delivered but is not cached.
            if (accept) begin
                invSeen <= 1'b0;
            end else if (inv) begin
                invSeen <= 1'b1;
            end
            if (fetchDone) begin
                tagValid <= !(inv || invSeen);
                tag      <= blkAddr;
            end else if (inv) begin
                tagValid <= 1'b0;
            end
        end
    end
`else
    logic unusedInv;
    assign unusedInv = inv;
    assign hit       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState     = state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        out_valid     = 1'b0;
        mem_addr      = blkAddr + AW'({beat, 2'b00});
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    nextState = hit ? OUT : REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (mem_rdata_valid) begin
                    nextState = (beat == 2'd3) ? OUT : REQ;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // out_data doubles as the cache data store: only a fetch writes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat       <= 2'd0;
            blkAddr    <= '0;
            out_data   <= '0;
            out_format <= '0;
            out_x      <= '0;
            out_y      <= '0;
        end else begin
            if (accept) begin
                beat       <= 2'd0;
                blkAddr    <= reqAddr;
                out_format <= req_format;
                out_x      <= req_u[1:0];
                out_y      <= req_v[1:0];
            end
            if ((state == WAIT) && mem_rdata_valid) begin
                out_data[{beat, 5'b00000} +: 32] <= mem_rdata;
                beat <= beat + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_anffl_tex_block_fetch.sv
// Self-checking bench for anffl_tex_block_fetch: vector table of misses
// plus hand sequences for hit, backpressure, invalidate, stall and reset.
module tb_anffl_tex_block_fetch;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [11:0]   req_u;
    logic [11:0]   req_v;
    logic [31:0]   req_base;
    logic [3:0]    req_pitch_log2;
    logic [4:0]    req_format;
    logic          inv;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [31:0]   mem_addr;
    logic          mem_rdata_valid;
    logic [31:0]   mem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_data;
    logic [4:0]    out_format;
    logic [1:0]    out_x;
    logic [1:0]    out_y;

    int checks = 0;
    int errors = 0;

    logic [31:0] addrLog[$];
    logic        injectSpur;
    logic        fire;
    logic [31:0] fAddr;

    typedef struct {
        logic [11:0] u;
        logic [11:0] v;
        logic [31:0] base;
        logic [3:0]  pl;
        logic [4:0]  fmt;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[6];

    anffl_tex_block_fetch #(.AW(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_u(req_u),
        .req_v(req_v),
        .req_base(req_base),
        .req_pitch_log2(req_pitch_log2),
        .req_format(req_format),
        .inv(inv),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr),
        .mem_rdata_valid(mem_rdata_valid),
        .mem_rdata(mem_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_format(out_format),
        .out_x(out_x),
        .out_y(out_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [127:0] blockData(input logic [31:0] a);
        return {memWord(a + 32'd12), memWord(a + 32'd8),
                memWord(a + 32'd4), memWord(a)};
    endfunction

    // Memory model: one-cycle read latency, optional spurious data pulse.
    initial begin
        mem_rdata_valid = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            fire = mem_req_valid && mem_req_ready;
            fAddr = mem_addr;
            if (fire) addrLog.push_back(fAddr);
            @(posedge clk);
            #1;
            mem_rdata_valid = fire || injectSpur;
            mem_rdata = fire ? memWord(fAddr) :
                        (injectSpur ? 32'hDEAD_BEEF : 32'h0);
        end
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic waitOut(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("out_valid_timeout", out_valid, 1);
    endtask

    task automatic doReq(input logic [11:0] u, input logic [11:0] v,
                         input logic [31:0] base, input logic [3:0] pl,
                         input logic [4:0] fmt, input logic doInv,
                         output int lat);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_u = u;
        req_v = v;
        req_base = base;
        req_pitch_log2 = pl;
        req_format = fmt;
        inv = doInv;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        inv = 1'b0;
        waitOut(lat);
    endtask

    task automatic checkFetch(input string nm, input int idx,
                              input logic [31:0] a);
        chk({nm, "_nwords"}, addrLog.size(), idx + 4);
        for (int k = 0; k < 4; k++) begin
            if (addrLog.size() > idx + k)
                chk($sformatf("%s_addr%0d", nm, k), addrLog[idx + k],
                    a + 32'(4 * k));
        end
    endtask

    // Checks the OUT bundle, then lets it retire (out_ready is high).
    task automatic checkOut(input string nm, input logic [31:0] a,
                            input logic [1:0] x, input logic [1:0] y,
                            input logic [4:0] fmt);
        chk({nm, "_data"}, out_data, blockData(a));
        chk({nm, "_x"}, out_x, x);
        chk({nm, "_y"}, out_y, y);
        chk({nm, "_fmt"}, out_format, fmt);
        @(posedge clk);
        #2;
    endtask

    task automatic checkZero(input string nm);
        chk({nm, "_out_valid"}, out_valid, 0);
        chk({nm, "_mem_req_valid"}, mem_req_valid, 0);
        chk({nm, "_out_data"}, out_data, 0);
        chk({nm, "_mem_addr"}, mem_addr, 0);
        chk({nm, "_xyf"}, {out_x, out_y, out_format}, 0);
        chk({nm, "_req_ready"}, req_ready, 1);
    endtask

    initial begin
        int lat;
        int idx;
        int n;
        logic [127:0] hold;

        rst_n = 1'b0;
        req_valid = 1'b0;
        req_u = '0;
        req_v = '0;
        req_base = '0;
        req_pitch_log2 = '0;
        req_format = '0;
        inv = 1'b0;
        mem_req_ready = 1'b1;
        out_ready = 1'b1;
        injectSpur = 1'b0;

        vecs[0] = '{12'd5, 12'd9, 32'h0000_1000, 4'd2, 5'd3, 32'h0000_1090};
        vecs[1] = '{12'h0FF, 12'h013, 32'h2000_0000, 4'd4, 5'd7,
                    32'h2000_07F0};
        vecs[2] = '{12'hFFF, 12'hFFF, 32'h0, 4'd15, 5'd31, 32'h1FF8_3FF0};
        vecs[3] = '{12'd3, 12'd2, 32'h0000_0104, 4'd0, 5'd1, 32'h0000_0104};
        vecs[4] = '{12'd4, 12'd0, 32'hFFFF_FFF0, 4'd3, 5'd2, 32'h0000_0000};
        vecs[5] = '{12'd8, 12'd4, 32'h0000_0400, 4'd1, 5'd9, 32'h0000_0440};

        repeat (2) @(negedge clk);
        checkZero("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        for (int i = 0; i < 6; i++) begin
            idx = addrLog.size();
            doReq(vecs[i].u, vecs[i].v, vecs[i].base, vecs[i].pl,
                  vecs[i].fmt, 1'b0, lat);
            chk($sformatf("vec%0d_lat", i), lat, 9);
            checkFetch($sformatf("vec%0d", i), idx, vecs[i].addr);
            checkOut($sformatf("vec%0d", i), vecs[i].addr,
                     vecs[i].u[1:0], vecs[i].v[1:0], vecs[i].fmt);
        end

        // Miss then same-block request.
        idx = addrLog.size();
        doReq(12'd5, 12'd9, 32'h1000, 4'd2, 5'd3, 1'b0, lat);
        chk("miss_lat", lat, 9);
        checkFetch("miss", idx, 32'h1090);
        checkOut("miss", 32'h1090, 2'd1, 2'd1, 5'd3);
        idx = addrLog.size();
        doReq(12'd6, 12'd10, 32'h1000, 4'd2, 5'd3, 1'b0, lat);
`ifdef ANFFL_TEX_FETCH_CACHE_EN
        chk("hit_lat", lat, 1);
        chk("hit_nwords", addrLog.size(), idx);
`else
        chk("nocache_lat", lat, 9);
        checkFetch("nocache", idx, 32'h1090);
`endif
        checkOut("hit", 32'h1090, 2'd2, 2'd2, 5'd3);

        // Backpressure on the output.
        out_ready = 1'b0;
        doReq(12'd7, 12'd11, 32'h1000, 4'd2, 5'd4, 1'b0, lat);
        hold = out_data;
        chk("bp_data0", hold, blockData(32'h1090));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp%0d_valid", i), out_valid, 1);
            chk($sformatf("bp%0d_rdy", i), req_ready, 0);
            chk($sformatf("bp%0d_data", i), out_data, blockData(32'h1090));
            chk($sformatf("bp%0d_xyf", i), {out_x, out_y, out_format},
                {2'd3, 2'd3, 5'd4});
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_rdy", req_ready, 1);
        chk("bp_release_valid", out_valid, 0);
        @(posedge clk);
        #2;

        // Invalidate during WAIT of beat 2.
        idx = addrLog.size();
        fork
            doReq(12'h20, 12'h20, 32'h8000, 4'd3, 5'd5, 1'b0, lat);
            begin
                n = 0;
                while (addrLog.size() < idx + 3 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                chk("inv_wait_bound", n < 50, 1);
                @(posedge clk);
                #2;
                inv = 1'b1;
                @(posedge clk);
                #2;
                inv = 1'b0;
            end
        join
        chk("inv_lat", lat, 9);
        checkFetch("inv", idx, 32'h8480);
        checkOut("inv", 32'h8480, 2'd0, 2'd0, 5'd5);
        idx = addrLog.size();
        doReq(12'h21, 12'h22, 32'h8000, 4'd3, 5'd5, 1'b0, lat);
        chk("refetch_lat", lat, 9);
        checkFetch("refetch", idx, 32'h8480);
        checkOut("refetch", 32'h8480, 2'd1, 2'd2, 5'd5);
`ifdef ANFFL_TEX_FETCH_CACHE_EN
        idx = addrLog.size();
        doReq(12'h22, 12'h21, 32'h8000, 4'd3, 5'd5, 1'b0, lat);
        chk("rehit_lat", lat, 1);
        chk("rehit_nwords", addrLog.size(), idx);
        checkOut("rehit", 32'h8480, 2'd2, 2'd1, 5'd5);
`endif
        // Invalidate coincident with accept forces a miss.
        idx = addrLog.size();
        doReq(12'h23, 12'h23, 32'h8000, 4'd3, 5'd6, 1'b1, lat);
        chk("invacc_lat", lat, 9);
        checkFetch("invacc", idx, 32'h8480);
        checkOut("invacc", 32'h8480, 2'd3, 2'd3, 5'd6);

        // Memory stall with a spurious data pulse while in REQ.
        mem_req_ready = 1'b0;
        idx = addrLog.size();
        req_valid = 1'b1;
        req_u = 12'h10;
        req_v = 12'h04;
        req_base = 32'h3000;
        req_pitch_log2 = 4'd2;
        req_format = 5'd8;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        injectSpur = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_valid", i), mem_req_valid, 1);
            chk($sformatf("stall%0d_addr", i), mem_addr, 32'h3080);
            @(posedge clk);
            #2;
            injectSpur = 1'b0;
        end
        mem_req_ready = 1'b1;
        waitOut(lat);
        checkFetch("stall", idx, 32'h3080);
        checkOut("stall", 32'h3080, 2'd0, 2'd0, 5'd8);

        // Address wrap, reset asserted in WAIT of beat 1.
        idx = addrLog.size();
        req_valid = 1'b1;
        req_u = 12'd0;
        req_v = 12'd0;
        req_base = 32'hFFFF_FFF0;
        req_pitch_log2 = 4'd0;
        req_format = 5'd2;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        n = 0;
        while (addrLog.size() < idx + 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_wait_bound", n < 50, 1);
        if (addrLog.size() >= idx + 2) begin
            chk("wrap_addr0", addrLog[idx], 32'hFFFF_FFF0);
            chk("wrap_addr1", addrLog[idx + 1], 32'hFFFF_FFF4);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        @(negedge clk);
        checkZero("inrst");
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkZero("postrst");
        @(posedge clk);
        #2;
        idx = addrLog.size();
        doReq(12'd0, 12'd0, 32'hFFFF_FFF0, 4'd0, 5'd2, 1'b0, lat);
        chk("wrap_lat", lat, 9);
        checkFetch("wrap", idx, 32'hFFFF_FFF0);
        checkOut("wrap", 32'hFFFF_FFF0, 2'd0, 2'd0, 5'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
